// File: rtl/uart_tx_sequencer_if.sv
// Producer push handshake plus the Uart 4-register bus port group.
// master = the sequencer's view; slave = producer/Uart environment view.
interface uart_tx_sequencer_if;
    logic        pushValid;
    logic [7:0]  pushData;
    logic        pushReady;
    logic [1:0]  busAddr;
    wire  [15:0] busData;
    logic        busEn;
    logic        busWr;
    logic        sigTxInt;

    modport master (
        input  pushValid, pushData, sigTxInt,
        output pushReady, busAddr, busData, busEn, busWr
    );

    modport slave (
        output pushValid, pushData, sigTxInt,
        input  pushReady, busAddr, busData, busEn, busWr
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Buffers producer bytes and writes them one at a time to the Uart TX register, pacing on the TX-complete edge;
// push-to-bus latency 2 cycles, pushReady drops only when FIFO full. Optional WAIT watchdog: UTS_TIMEOUT_EN.
module uart_tx_sequencer #(
    parameter logic [1:0]  TXDATA_ADDR = 2'd0,
    parameter logic [1:0]  CTRL_ADDR   = 2'd1,
    parameter logic [15:0] CTRL_INIT   = 16'h0001,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          TIMEOUT     = 1024
) (
    input  logic                             clk,
    input  logic                             rstn,
    uart_tx_sequencer_if.master              bus,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifoCount,
    output logic                             errTimeout
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_WAIT
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           txint_q;

    logic           push;
    logic           pop;
    logic           full;
    logic           tx_edge;
    logic           timeout_hit;
    logic           drv_en;
    logic [1:0]     drv_addr;
    logic [15:0]    drv_data;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign push    = bus.pushValid & ~full;
    assign tx_edge = bus.sigTxInt & ~txint_q;

    // FIFO bookkeeping: count is its own register so full/empty never need pointer compares.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        drv_en   = 1'b0;
        drv_addr = 2'd0;
        drv_data = 16'h0000;
        pop      = 1'b0;
        case (state_q)
            S_INIT: begin
                drv_en   = 1'b1;
                drv_addr = CTRL_ADDR;
                drv_data = CTRL_INIT;
                state_d  = S_IDLE;
            end
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                drv_en   = 1'b1;
                drv_addr = TXDATA_ADDR;
                drv_data = {8'h00, mem_q[rd_ptr_q]};
                pop      = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (tx_edge || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_INIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            txint_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            txint_q  <= bus.sigTxInt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.pushData;
        end
    end

`ifdef UTS_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;

    assign timeout_hit = (state_q == S_WAIT) && !tx_edge && (wcnt_q == TW'(TIMEOUT - 1));

    // Held at zero outside WAIT, so every WAIT visit starts counting from 0.
    always_comb begin
        wcnt_d = wcnt_q;
        err_d  = err_q;
        if (state_q != S_WAIT) begin
            wcnt_d = '0;
        end else if (!tx_edge) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    assign errTimeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign errTimeout  = 1'b0;
`endif

    // The state register resets to INIT, so the bus is also gated by rstn to stay quiet while held in reset.
    assign bus.busEn     = drv_en & rstn;
    assign bus.busWr     = drv_en & rstn;
    assign bus.busAddr   = rstn ? drv_addr : 2'd0;
    assign bus.busData   = (drv_en & rstn) ? drv_data : 16'hzzzz;
    assign bus.pushReady = ~full;

    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign fifoCount = count_q;

endmodule
